// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the sys_ctrl command decoder: opcodes, FSM states,
// and the register file slots that hold the ALU operands.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR      = 8'hAA;
    localparam logic [7:0] CMD_RF_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPER   = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOOPER = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUN,
        ALU_WAIT,
        SEND_LSB,
        SEND_MSB,
        SEND_RD
    } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// UART command decoder: turns received byte frames into register file
// accesses and ALU operations, and queues results back to the TX FIFO.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                      Ref_clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     rx_p_data,
    input  logic                      rx_d_valid,
    input  logic [2*DATA_WIDTH-1:0]   alu_out,
    input  logic                      alu_out_valid,
    input  logic [DATA_WIDTH-1:0]     rf_rd_data,
    input  logic                      rf_rd_data_valid,
    input  logic                      fifo_full,
    output logic [ADDR_WIDTH-1:0]     rf_addr,
    output logic [DATA_WIDTH-1:0]     rf_wr_data,
    output logic                      rf_wr_en,
    output logic                      rf_rd_en,
    output logic [3:0]                alu_fun,
    output logic                      alu_en,
    output logic                      gate_en,
    output logic [DATA_WIDTH-1:0]     tx_p_data,
    output logic                      tx_d_valid
);

    state_t                    state_q;
    logic [ADDR_WIDTH-1:0]     rf_addr_q;
    logic [DATA_WIDTH-1:0]     rf_wr_data_q;
    logic                      rf_wr_en_q;
    logic                      rf_rd_en_q;
    logic [3:0]                alu_fun_q;
    logic                      alu_en_q;
    logic                      gate_en_q;
    logic [DATA_WIDTH-1:0]     tx_p_data_q;
    logic                      tx_d_valid_q;
    logic [2*DATA_WIDTH-1:0]   result_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;

    always_ff @(posedge Ref_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            gate_en_q    <= 1'b0;
            tx_p_data_q  <= '0;
            tx_d_valid_q <= 1'b0;
            result_q     <= '0;
            rd_data_q    <= '0;
        end else begin
            // Strobes are one-cycle pulses; only the state that owns one re-raises it.
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_en_q     <= 1'b0;
            tx_d_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rx_d_valid) begin
                        if (rx_p_data == DATA_WIDTH'(CMD_RF_WR)) begin
                            state_q <= WR_ADDR;
                        end else if (rx_p_data == DATA_WIDTH'(CMD_RF_RD)) begin
                            state_q <= RD_ADDR;
                        end else if (rx_p_data == DATA_WIDTH'(CMD_ALU_OPER)) begin
                            state_q <= OP_A;
                        end else if (rx_p_data == DATA_WIDTH'(CMD_ALU_NOOPER)) begin
                            state_q   <= ALU_FUN;
                            gate_en_q <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (rx_d_valid) begin
                        rf_addr_q <= rx_p_data[ADDR_WIDTH-1:0];
                        state_q   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (rx_d_valid) begin
                        rf_wr_data_q <= rx_p_data;
                        rf_wr_en_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (rx_d_valid) begin
                        rf_addr_q  <= rx_p_data[ADDR_WIDTH-1:0];
                        rf_rd_en_q <= 1'b1;
                        state_q    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rf_rd_data_valid) begin
                        rd_data_q <= rf_rd_data;
                        state_q   <= SEND_RD;
                    end
                end
                OP_A: begin
                    if (rx_d_valid) begin
                        rf_addr_q    <= ADDR_WIDTH'(OPA_ADDR);
                        rf_wr_data_q <= rx_p_data;
                        rf_wr_en_q   <= 1'b1;
                        state_q      <= OP_B;
                    end
                end
                OP_B: begin
                    if (rx_d_valid) begin
                        rf_addr_q    <= ADDR_WIDTH'(OPB_ADDR);
                        rf_wr_data_q <= rx_p_data;
                        rf_wr_en_q   <= 1'b1;
                        state_q      <= ALU_FUN;
                        gate_en_q    <= 1'b1;
                    end
                end
                ALU_FUN: begin
                    if (rx_d_valid) begin
                        alu_fun_q <= rx_p_data[3:0];
                        alu_en_q  <= 1'b1;
                        state_q   <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    if (alu_out_valid) begin
                        result_q  <= alu_out;
                        gate_en_q <= 1'b0;
                        state_q   <= SEND_LSB;
                    end
                end
                // A full FIFO stalls in place; tx_p_data keeps its last value.
                SEND_LSB: begin
                    if (!fifo_full) begin
                        tx_p_data_q  <= result_q[DATA_WIDTH-1:0];
                        tx_d_valid_q <= 1'b1;
                        state_q      <= SEND_MSB;
                    end
                end
                SEND_MSB: begin
                    if (!fifo_full) begin
                        tx_p_data_q  <= result_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        tx_d_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                SEND_RD: begin
                    if (!fifo_full) begin
                        tx_p_data_q  <= rd_data_q;
                        tx_d_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign alu_fun    = alu_fun_q;
    assign alu_en     = alu_en_q;
    assign gate_en    = gate_en_q;
    assign tx_p_data  = tx_p_data_q;
    assign tx_d_valid = tx_d_valid_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: command frames are expanded into the strobes they must
// produce, and a monitor matches every strobe the block raises against them.
module tb_sys_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    localparam int K_ALU = 3;
    localparam int K_TX  = 4;

    logic            Ref_clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   rx_p_data;
    logic            rx_d_valid;
    logic [2*DW-1:0] alu_out;
    logic            alu_out_valid;
    logic [DW-1:0]   rf_rd_data;
    logic            rf_rd_data_valid;
    logic            fifo_full;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_wr_data;
    logic            rf_wr_en;
    logic            rf_rd_en;
    logic [3:0]      alu_fun;
    logic            alu_en;
    logic            gate_en;
    logic [DW-1:0]   tx_p_data;
    logic            tx_d_valid;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    int          mon_n;
    logic [31:0] mon_act;
    int          kind;
    int          full_n;
    bit          junk;
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] r16;

    sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Ref_clk          (Ref_clk),
        .rst_n            (rst_n),
        .rx_p_data        (rx_p_data),
        .rx_d_valid       (rx_d_valid),
        .alu_out          (alu_out),
        .alu_out_valid    (alu_out_valid),
        .rf_rd_data       (rf_rd_data),
        .rf_rd_data_valid (rf_rd_data_valid),
        .fifo_full        (fifo_full),
        .rf_addr          (rf_addr),
        .rf_wr_data       (rf_wr_data),
        .rf_wr_en         (rf_wr_en),
        .rf_rd_en         (rf_rd_en),
        .alu_fun          (alu_fun),
        .alu_en           (alu_en),
        .gate_en          (gate_en),
        .tx_p_data        (tx_p_data),
        .tx_d_valid       (tx_d_valid)
    );

    always #5 Ref_clk = ~Ref_clk;

    function automatic logic [31:0] ev(input int k, input int a, input int d);
        ev = {8'(k), 8'(a), 16'(d)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge Ref_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_p_data  = b;
        rx_d_valid = 1'b1;
        tick(1);
        rx_d_valid = 1'b0;
        rx_p_data  = 8'($urandom);
        tick(int'($urandom_range(0, 2)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        tick(1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_strobes"}, {rf_wr_en, rf_rd_en, alu_en, tx_d_valid, gate_en}, 0);
        check({name, "_data"}, {rf_addr, rf_wr_data, alu_fun, tx_p_data}, 0);
    endtask

    // Deliver the read/ALU response, optionally with a full FIFO and a stray byte.
    task automatic result_phase(input bit is_alu, input logic [15:0] r, input int fn, input bit jk);
        logic [DW-1:0] held;
        if (jk) send_byte(8'($urandom));
        if (is_alu) check("gate_en_busy", gate_en, 1);
        if (fn > 0) fifo_full = 1'b1;
        if (is_alu) begin
            alu_out       = r;
            alu_out_valid = 1'b1;
        end else begin
            rf_rd_data       = r[7:0];
            rf_rd_data_valid = 1'b1;
        end
        tick(1);
        alu_out_valid    = 1'b0;
        rf_rd_data_valid = 1'b0;
        if (is_alu) check("gate_en_done", gate_en, 0);
        if (fn > 0) begin
            held = tx_p_data;
            for (int i = 0; i < fn; i++) begin
                rx_d_valid = (i == 1);
                rx_p_data  = 8'($urandom);
                tick(1);
                check("no_tx_while_full", tx_d_valid, 0);
                check("tx_data_stable", tx_p_data, held);
            end
            rx_d_valid = 1'b0;
            fifo_full  = 1'b0;
        end
        drain();
    endtask

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(ev(K_WR, int'(a) % 16, d));
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        drain();
    endtask

    task automatic cmd_read(input logic [7:0] a, input logic [7:0] r, input int fn, input bit jk);
        exp_q.push_back(ev(K_RD, int'(a) % 16, 0));
        exp_q.push_back(ev(K_TX, 0, r));
        send_byte(8'hBB);
        send_byte(a);
        result_phase(1'b0, {8'h00, r}, fn, jk);
    endtask

    task automatic cmd_alu(input bit ops, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] f, input logic [15:0] r, input int fn, input bit jk);
        check("gate_en_idle", gate_en, 0);
        if (ops) begin
            exp_q.push_back(ev(K_WR, 0, a));
            exp_q.push_back(ev(K_WR, 1, b));
        end
        exp_q.push_back(ev(K_ALU, int'(f) % 16, 0));
        exp_q.push_back(ev(K_TX, 0, r % 256));
        exp_q.push_back(ev(K_TX, 0, r / 256));
        send_byte(ops ? 8'hCC : 8'hDD);
        if (ops) begin
            send_byte(a);
            send_byte(b);
        end
        send_byte(f);
        result_phase(1'b1, r, fn, jk);
    endtask

    always @(negedge Ref_clk) begin
        if (rst_n) begin
            mon_n = int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(tx_d_valid);
            if (mon_n > 1) check("one_strobe", mon_n, 1);
            if (mon_n != 0) begin
                if (rf_wr_en)      mon_act = ev(K_WR, int'(rf_addr), int'(rf_wr_data));
                else if (rf_rd_en) mon_act = ev(K_RD, int'(rf_addr), 0);
                else if (alu_en)   mon_act = ev(K_ALU, int'(alu_fun), 0);
                else               mon_act = ev(K_TX, 0, int'(tx_p_data));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got 0x%0h, expected none", mon_act);
                end else begin
                    check("scoreboard", mon_act, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n            = 1'b0;
        rx_p_data        = '0;
        rx_d_valid       = 1'b0;
        alu_out          = '0;
        alu_out_valid    = 1'b0;
        rf_rd_data       = '0;
        rf_rd_data_valid = 1'b0;
        fifo_full        = 1'b0;
        @(posedge Ref_clk);
        #1;
        tick(2);
        check_reset_outputs("rst_initial");
        rst_n = 1'b1;
        tick(1);

        cmd_write(8'h05, 8'h19);
        cmd_read(8'h02, 8'h19, 0, 1'b0);
        cmd_alu(1'b1, 8'h0B, 8'h0F, 8'h00, 16'h001A, 0, 1'b0);
        cmd_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'h7D83, 10, 1'b0);

        send_byte(8'h55);
        tick(2);
        send_byte(8'hAA);
        rst_n      = 1'b0;
        rx_p_data  = 8'h01;
        rx_d_valid = 1'b1;
        tick(1);
        rx_d_valid = 1'b0;
        tick(1);
        check_reset_outputs("rst_midcmd");
        rst_n = 1'b1;
        tick(1);
        cmd_write(8'h03, 8'h07);

        for (int n = 0; n < 40; n++) begin
            kind   = int'($urandom_range(0, 4));
            full_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            junk   = ($urandom_range(0, 2) == 0);
            b0  = 8'($urandom);
            b1  = 8'($urandom);
            b2  = 8'($urandom);
            r16 = 16'($urandom);
            case (kind)
                0: cmd_write(b0, b1);
                1: cmd_read(b0, b1, full_n, junk);
                2: cmd_alu(1'b1, b0, b1, b2, r16, full_n, junk);
                3: cmd_alu(1'b0, b0, b1, b2, r16, full_n, junk);
                default: begin
                    do b3 = 8'($urandom);
                    while (b3 == 8'hAA || b3 == 8'hBB || b3 == 8'hCC || b3 == 8'hDD);
                    send_byte(b3);
                    tick(3);
                end
            endcase
        end

        tick(5);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the UART byte, register file data and ALU operands.
REQ-002 Parameter ADDR_WIDTH, default 4, register file address width.
REQ-003 Ref_clk  in  1  sole clock (reference domain); all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 rx_p_data  in  DATA_WIDTH  received UART byte, already synchronised to Ref_clk.
REQ-006 rx_d_valid  in  1  one-cycle pulse; rx_p_data is valid that cycle.
REQ-007 alu_out  in  2*DATA_WIDTH  ALU result.
REQ-008 alu_out_valid  in  1  one-cycle pulse; alu_out is valid that cycle.
REQ-009 rf_rd_data  in  DATA_WIDTH  register file read data.
REQ-010 rf_rd_data_valid  in  1  one-cycle pulse; rf_rd_data is valid that cycle.
REQ-011 fifo_full  in  1  TX FIFO full; writes are forbidden while high.
REQ-012 rf_addr  out  ADDR_WIDTH  register file address.
REQ-013 rf_wr_data  out  DATA_WIDTH  register file write data.
REQ-014 rf_wr_en / rf_rd_en  out  1 each  one-cycle register file write/read strobes.
REQ-015 alu_fun  out  4  ALU function code; alu_en  out  1  one-cycle ALU start strobe.
REQ-016 gate_en  out  1  ALU clock-gate enable.
REQ-017 tx_p_data  out  DATA_WIDTH  byte to TX FIFO; tx_d_valid  out  1  one-cycle FIFO write strobe.

Function
REQ-018 Command bytes SHALL be: 0xAA reg write (addr, data), 0xBB reg read (addr), 0xCC ALU with operands (A, B, fun), 0xDD ALU without operands (fun).
REQ-019 States SHALL be: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, SEND_LSB, SEND_MSB, SEND_RD.
REQ-020 IDLE: rx_d_valid with 0xAA/0xBB/0xCC/0xDD SHALL go to WR_ADDR/RD_ADDR/OP_A/ALU_FUN respectively; any other byte is dropped and the state stays IDLE.
REQ-021 Each byte-collecting state (WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN) SHALL wait indefinitely for rx_d_valid, with no timeout.
REQ-022 WR_ADDR: latch rx_p_data[ADDR_WIDTH-1:0] as the address, then go to WR_DATA.
REQ-023 WR_DATA: on the next byte, assert rf_wr_en for exactly one cycle, in the cycle after rx_d_valid, with the latched address and the byte; then go to IDLE.
REQ-024 RD_ADDR: on the address byte, assert rf_rd_en for one cycle with rf_addr, then go to RD_WAIT.
REQ-025 RD_WAIT: on rf_rd_data_valid, capture rf_rd_data and go to SEND_RD.
REQ-026 OP_A / OP_B: each byte SHALL produce a one-cycle rf_wr_en, to address 0 for operand A and address 1 for operand B, then advance to OP_B / ALU_FUN.
REQ-027 ALU_FUN: on the function byte, drive alu_fun=rx_p_data[3:0] and pulse alu_en for one cycle, then go to ALU_WAIT.
REQ-028 gate_en SHALL be asserted from ALU_FUN entry until the cycle alu_out_valid is seen, and deasserted otherwise.
REQ-029 ALU_WAIT: on alu_out_valid, capture alu_out and go to SEND_LSB.
REQ-030 SEND_* states: when fifo_full=0, pulse tx_d_valid for one cycle.
REQ-031 SEND_LSB sends result[7:0] then goes to SEND_MSB; SEND_MSB sends result[15:8] then goes to IDLE; SEND_RD sends the captured read byte then goes to IDLE.
REQ-032 While fifo_full=1, the block SHALL remain in the current SEND_* state with tx_d_valid=0 and tx_p_data stable.
REQ-033 rx_d_valid arriving in RD_WAIT, ALU_WAIT or any SEND_* state SHALL be ignored (byte dropped).
REQ-034 All strobes SHALL be registered outputs; at most one of rf_wr_en, rf_rd_en, alu_en, tx_d_valid is high in any cycle.

Reset
REQ-035 rst_n=0 at a Ref_clk edge SHALL force IDLE and all outputs to 0, and clear the captured result, address and read-data registers.
REQ-036 Reset mid-command SHALL abort the command; the first byte after release is decoded as a command byte.

Structure
REQ-037 A shared package SHALL hold the command opcode constants (0xAA, 0xBB, 0xCC, 0xDD), the state enum, and the operand A/B register addresses (0, 1).
REQ-038 The block is a single module with no sub-modules.

Verification
REQ-039 Bytes 0xAA,0x05,0x19 -> one rf_wr_en with rf_addr=5 and rf_wr_data=0x19; no tx_d_valid.
REQ-040 Bytes 0xBB,0x02, then rf_rd_data=0x19 with rf_rd_data_valid -> rf_rd_en with rf_addr=2, then one tx_d_valid with tx_p_data=0x19.
REQ-041 Bytes 0xCC,0x0B,0x0F,0x00, then alu_out=0x001A -> writes addr0=0x0B and addr1=0x0F, alu_en with alu_fun=0, then tx bytes 0x1A, 0x00 in order; gate_en high during the ALU op.
REQ-042 Bytes 0xDD,0x02, with alu_out=0x7D83 and fifo_full held high 10 cycles -> no tx_d_valid while full, then tx bytes 0x83, 0x7D.
REQ-043 Byte 0x55 in IDLE, then 0xAA,0x01 with reset asserted, then 0xAA,0x03,0x07 -> no strobe for the 0x55 or the aborted command; one rf_wr_en with addr=3, data=0x07.
